lane_note_dropper: RTL and testbench

Parametrised single-lane note engine for the rhythm game. It holds up to `SLOTS` concurrently falling notes in one lane and spawns them on request from the chart sequencer. Each frame it advances every active note, judges key presses as perfect, good or miss, and keeps score and combo. It feeds the sprite renderer with per-slot positions and feeds the HUD with score and combo.

---
 rtl/lane_note_dropper.sv | 204 ++++++++++++++++++++
 tb/tb_lane_note_dropper.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_note_dropper.sv
// Single-lane rhythm-game note engine: spawns, advances and judges up to SLOTS falling notes.
// Optional `LANE_KEY_EDGE_EN`: key events need a rising edge of the lane key (default: key level).
module lane_note_dropper #(
  parameter int unsigned X_START  = 160,
  parameter int unsigned Y_START  = 100,
  parameter int unsigned Y_MAX    = 400,
  parameter int unsigned SPRITE_H = 40,
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SPEED    = 1,
  parameter logic [7:0]  LANE_KEY = 8'h07,
  parameter int unsigned GOOD_LO  = 340,
  parameter int unsigned PERF_LO  = 370,
  parameter int unsigned PERF_HI  = 390
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [7:0]            keycode,
  input  logic [7:0]            keycode_second,
  input  logic                  spawn,
  input  logic                  chart_end,
  output logic [9:0]            lane_x,
  output logic [10*SLOTS-1:0]   slot_y,
  output logic [SLOTS-1:0]      slot_active,
  output logic                  hit_perfect,
  output logic                  hit_good,
  output logic                  miss,
  output logic                  spawn_drop,
  output logic [15:0]           score,
  output logic [7:0]            combo,
  output logic                  running
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0]  KEY_SPACE  = 8'h2C;
  localparam logic [7:0]  KEY_EXIT   = 8'h01;
  localparam logic [9:0]  X_START_W  = 10'(X_START);
  localparam logic [9:0]  Y_START_W  = 10'(Y_START);
  localparam logic [9:0]  SPEED_W    = 10'(SPEED);
  localparam logic [10:0] Y_MAX_W    = 11'(Y_MAX);
  localparam logic [10:0] SPRITE_H_W = 11'(SPRITE_H);
  localparam logic [10:0] GOOD_LO_W  = 11'(GOOD_LO);
  localparam logic [10:0] PERF_LO_W  = 11'(PERF_LO);
  localparam logic [10:0] PERF_HI_W  = 11'(PERF_HI);

  state_t            state_q, state_d;
  logic [9:0]        y_q [SLOTS];
  logic [9:0]        y_d [SLOTS];
  logic [SLOTS-1:0]  active_q, active_d;
  logic [15:0]       score_q, score_d;
  logic [7:0]        combo_q, combo_d;
  logic              hit_perfect_q, hit_perfect_d;
  logic              hit_good_q, hit_good_d;
  logic              miss_q, miss_d;
  logic              spawn_drop_q, spawn_drop_d;
  logic              running_q, running_d;

  logic              key_now, key_event;
  logic [10:0]       bottom [SLOTS];
  logic [SLOTS-1:0]  miss_vec, cand_vec, hit_vec, spawn_vec;
  logic              tgt_found, spawn_free, hit, perfect;
  logic [9:0]        best_y;
  logic [10:0]       tgt_bottom;
  logic [16:0]       score_sum;

  assign key_now = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);

`ifdef LANE_KEY_EDGE_EN
  logic prev_key_q;
  assign key_event = key_now && !prev_key_q;
  always_ff @(posedge frame_clk) begin
    if (Reset) prev_key_q <= 1'b0;
    else       prev_key_q <= key_now;
  end
`else
  assign key_event = key_now;
`endif

  // Judgement: misses, then the lowest-placed candidate (largest y, lowest index on ties).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    tgt_found  = 1'b0;
    best_y     = '0;
    hit_vec    = '0;
    spawn_vec  = '0;
    spawn_free = 1'b0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      bottom[i]   = {1'b0, y_q[i]} + SPRITE_H_W;
      miss_vec[i] = active_q[i] && (bottom[i] >= Y_MAX_W);
      cand_vec[i] = active_q[i] && !miss_vec[i] && (bottom[i] >= GOOD_LO_W);
    end
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (cand_vec[i] && (!tgt_found || y_q[i] > best_y)) begin
        tgt_found  = 1'b1;
        best_y     = y_q[i];
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
      end
      if (!active_q[i] && !spawn_free) begin
        spawn_free   = 1'b1;
        spawn_vec[i] = 1'b1;
      end
    end
    tgt_bottom = {1'b0, best_y} + SPRITE_H_W;
    hit        = key_event && tgt_found;
    perfect    = (tgt_bottom >= PERF_LO_W) && (tgt_bottom < PERF_HI_W);
    score_sum  = {1'b0, score_q} + (perfect ? 17'd2 : 17'd1);
  end

  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    active_d      = active_q;
    score_d       = score_q;
    combo_d       = combo_q;
    hit_perfect_d = 1'b0;
    hit_good_d    = 1'b0;
    miss_d        = 1'b0;
    spawn_drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        active_d = '0;
        for (int i = 0; i < int'(SLOTS); i++) y_d[i] = Y_START_W;
        if (keycode == KEY_SPACE || keycode_second == KEY_SPACE) begin
          score_d = '0;
          combo_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hit_perfect_d = hit && perfect;
        hit_good_d    = hit && !perfect;
        miss_d        = |miss_vec;
        spawn_drop_d  = spawn && !spawn_free;
        if (hit) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (hit && |miss_vec)  combo_d = 8'd1;
        else if (hit)          combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        else if (|miss_vec)    combo_d = 8'd0;
        // Slots freed this frame are not spawn targets: spawn_vec only sees active_q.
        for (int i = 0; i < int'(SLOTS); i++) begin
          if (miss_vec[i] || (hit && hit_vec[i])) begin
            active_d[i] = 1'b0;
            y_d[i]      = Y_START_W;
          end else if (spawn && spawn_vec[i]) begin
            active_d[i] = 1'b1;
            y_d[i]      = Y_START_W;
          end else if (active_q[i]) begin
            y_d[i] = y_q[i] + SPEED_W;
          end
        end
        if (chart_end && active_d == '0) state_d = DONE;
      end
      DONE: begin
        if (keycode == KEY_EXIT || keycode_second == KEY_EXIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      active_q      <= '0;
      // NOTE: the y array is reset too, because the renderer must see Y_START right after reset.
      for (int i = 0; i < int'(SLOTS); i++) y_q[i] <= Y_START_W;
      score_q       <= '0;
      combo_q       <= '0;
      hit_perfect_q <= 1'b0;
      hit_good_q    <= 1'b0;
      miss_q        <= 1'b0;
      spawn_drop_q  <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      for (int i = 0; i < int'(SLOTS); i++) y_q[i] <= y_d[i];
      score_q       <= score_d;
      combo_q       <= combo_d;
      hit_perfect_q <= hit_perfect_d;
      hit_good_q    <= hit_good_d;
      miss_q        <= miss_d;
      spawn_drop_q  <= spawn_drop_d;
      running_q     <= running_d;
    end
  end

  always_comb begin
    slot_y = '0;
    for (int i = 0; i < int'(SLOTS); i++) slot_y[10*i +: 10] = y_q[i];
  end

  assign lane_x      = X_START_W;
  assign slot_active = active_q;
  assign hit_perfect = hit_perfect_q;
  assign hit_good    = hit_good_q;
  assign miss        = miss_q;
  assign spawn_drop  = spawn_drop_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign running     = running_q;

endmodule

// File: tb/tb_lane_note_dropper.sv
// Self-checking bench for lane_note_dropper: directed scenarios plus random frames vs a note-list model.
module tb_lane_note_dropper;

  localparam int X_START = 160, Y_START = 100, Y_MAX = 400, SPRITE_H = 40;
  localparam int SLOTS = 4, SPEED = 1, GOOD_LO = 340, PERF_LO = 370, PERF_HI = 390;
  localparam logic [7:0] LANE_KEY = 8'h07;

  logic                frame_clk = 1'b0;
  logic                Reset = 1'b1;
  logic [7:0]          keycode = '0, keycode_second = '0;
  logic                spawn = 1'b0, chart_end = 1'b0;
  logic [9:0]          lane_x;
  logic [10*SLOTS-1:0] slot_y;
  logic [SLOTS-1:0]    slot_active;
  logic                hit_perfect, hit_good, miss, spawn_drop, running;
  logic [15:0]         score;
  logic [7:0]          combo;

  lane_note_dropper #(
    .X_START(X_START), .Y_START(Y_START), .Y_MAX(Y_MAX), .SPRITE_H(SPRITE_H),
    .SLOTS(SLOTS), .SPEED(SPEED), .LANE_KEY(LANE_KEY),
    .GOOD_LO(GOOD_LO), .PERF_LO(PERF_LO), .PERF_HI(PERF_HI)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
    .spawn(spawn), .chart_end(chart_end), .lane_x(lane_x), .slot_y(slot_y),
    .slot_active(slot_active), .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss),
    .spawn_drop(spawn_drop), .score(score), .combo(combo), .running(running)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one record per lane slot, judged with integer pixel arithmetic.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  bit      m_act [SLOTS];
  int      m_y   [SLOTS];
  int      m_score = 0, m_combo = 0;
  bit      m_hp = 0, m_hg = 0, m_miss = 0, m_drop = 0, m_prev = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input logic [7:0] k1, input logic [7:0] k2,
                            input bit sp, input bit ce);
    bit key_now, ev, any_miss, hit, perf, any_act;
    bit missed [SLOTS];
    int tgt, free_i, bot;
    key_now = (k1 == LANE_KEY) || (k2 == LANE_KEY);
`ifdef LANE_KEY_EDGE_EN
    ev = key_now && !m_prev;
`else
    ev = key_now;
`endif
    m_hp = 0; m_hg = 0; m_miss = 0; m_drop = 0;
    if (rst) begin
      m_state = M_IDLE; m_score = 0; m_combo = 0; m_prev = 0;
      for (int i = 0; i < SLOTS; i++) begin m_act[i] = 0; m_y[i] = Y_START; end
      return;
    end
    m_prev = key_now;
    case (m_state)
      M_IDLE: if (k1 == 8'h2C || k2 == 8'h2C) begin
        m_score = 0; m_combo = 0; m_state = M_RUN;
      end
      M_DONE: if (k1 == 8'h01 || k2 == 8'h01) m_state = M_IDLE;
      default: begin
        any_miss = 0; tgt = -1; free_i = -1;
        for (int i = 0; i < SLOTS; i++) begin
          missed[i] = m_act[i] && (m_y[i] + SPRITE_H >= Y_MAX);
          if (missed[i]) any_miss = 1;
        end
        for (int i = 0; i < SLOTS; i++) begin
          if (m_act[i] && !missed[i] && m_y[i] + SPRITE_H >= GOOD_LO &&
              (tgt < 0 || m_y[i] > m_y[tgt])) tgt = i;
          if (!m_act[i] && free_i < 0) free_i = i;
        end
        hit = ev && (tgt >= 0);
        if (hit) begin
          bot  = m_y[tgt] + SPRITE_H;
          perf = (bot >= PERF_LO) && (bot < PERF_HI);
          m_hp = perf; m_hg = !perf;
          m_score = m_score + (perf ? 2 : 1);
          if (m_score > 65535) m_score = 65535;
        end
        if (hit && any_miss) m_combo = 1;
        else if (hit)        m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
        else if (any_miss)   m_combo = 0;
        m_miss = any_miss;
        m_drop = sp && (free_i < 0);
        any_act = 0;
        for (int i = 0; i < SLOTS; i++) begin
          if (missed[i] || (hit && i == tgt)) begin m_act[i] = 0; m_y[i] = Y_START; end
          else if (sp && i == free_i)       begin m_act[i] = 1; m_y[i] = Y_START; end
          else if (m_act[i])                m_y[i] = m_y[i] + SPEED;
          if (m_act[i]) any_act = 1;
        end
        if (ce && !any_act) m_state = M_DONE;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [10*SLOTS-1:0] ey;
    logic [SLOTS-1:0]    ea;
    for (int i = 0; i < SLOTS; i++) begin
      ey[10*i +: 10] = 10'(m_y[i]);
      ea[i]          = m_act[i];
    end
    check("lane_x",      64'(lane_x),      64'(X_START));
    check("slot_y",      64'(slot_y),      64'(ey));
    check("slot_active", 64'(slot_active), 64'(ea));
    check("hit_perfect", 64'(hit_perfect), 64'(m_hp));
    check("hit_good",    64'(hit_good),    64'(m_hg));
    check("miss",        64'(miss),        64'(m_miss));
    check("spawn_drop",  64'(spawn_drop),  64'(m_drop));
    check("score",       64'(score),       64'(m_score));
    check("combo",       64'(combo),       64'(m_combo));
    check("running",     64'(running),     64'(m_state == M_RUN));
  endtask

  task automatic frame(input bit rst, input logic [7:0] k1, input logic [7:0] k2,
                       input bit sp, input bit ce);
    Reset = rst; keycode = k1; keycode_second = k2; spawn = sp; chart_end = ce;
    @(posedge frame_clk);
    model_edge(rst, k1, k2, sp, ce);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) frame(0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic start_run();
    frame(1, 8'h00, 8'h00, 0, 0);
    frame(0, 8'h2C, 8'h00, 0, 0);
  endtask

  initial begin
    int r;
    logic [7:0] k1, k2;

    // Reset state
    #1;
    frame(1, 8'h00, 8'h00, 0, 0);
    check("reset_active", 64'(slot_active), 64'd0);
    check("reset_y",      64'(slot_y[9:0]), 64'(Y_START));
    check("reset_run",    64'(running),     64'd0);
    frame(0, 8'h2C, 8'h00, 0, 0);
    check("run_after_space", 64'(running), 64'd1);

    // Perfect hit at bottom 375
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(235);
    frame(0, LANE_KEY, 8'h00, 0, 0);
    check("perfect_pulse", 64'(hit_perfect),    64'd1);
    check("perfect_score", 64'(score),          64'd2);
    check("perfect_combo", 64'(combo),          64'd1);
    check("perfect_slot0", 64'(slot_active[0]), 64'd0);

    // Miss at bottom 400 clears the combo
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(261);
    check("miss_pulse", 64'(miss),           64'd1);
    check("miss_combo", 64'(combo),          64'd0);
    check("miss_slot0", 64'(slot_active[0]), 64'd0);

    // Good window lower boundary
    start_run();
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(199);
    frame(0, LANE_KEY, 8'h00, 0, 0);
    check("b339_good",  64'(hit_good),       64'd0);
    check("b339_score", 64'(score),          64'd0);
    check("b339_slot",  64'(slot_active[0]), 64'd1);
    start_run();
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(200);
    frame(0, LANE_KEY, 8'h00, 0, 0);
    check("b340_good",  64'(hit_good), 64'd1);
    check("b340_score", 64'(score),    64'd1);
    start_run();
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(200);
    frame(0, 8'h00, LANE_KEY, 0, 0);
    check("second_good",  64'(hit_good), 64'd1);
    check("second_score", 64'(score),    64'd1);

    // Held key across two notes in the window
    start_run();
    frame(0, 8'h00, 8'h00, 1, 0);
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(205);
    frame(0, LANE_KEY, 8'h00, 0, 0);
    check("held_first", 64'(hit_good), 64'd1);
    frame(0, LANE_KEY, 8'h00, 0, 0);
`ifdef LANE_KEY_EDGE_EN
    check("held_no_second", 64'(hit_good),    64'd0);
    check("held_active",    64'(slot_active), 64'h2);
`endif
    frame(0, 8'h00, 8'h00, 0, 0);
    frame(0, LANE_KEY, 8'h00, 0, 0);
`ifdef LANE_KEY_EDGE_EN
    check("repress_hit",    64'(hit_good),    64'd1);
    check("repress_active", 64'(slot_active), 64'd0);
`endif

    // Overflow: fifth consecutive spawn is dropped
    start_run();
    repeat (4) frame(0, 8'h00, 8'h00, 1, 0);
    check("ovf_active", 64'(slot_active), 64'hF);
    frame(0, 8'h00, 8'h00, 1, 0);
    check("ovf_drop",    64'(spawn_drop),  64'd1);
    check("ovf_active5", 64'(slot_active), 64'hF);

    // Reset mid-flight
    idle(50);
    frame(0, 8'h00, 8'h00, 0, 0);
    frame(1, LANE_KEY, 8'h2C, 1, 1);
    check("rst_active", 64'(slot_active), 64'd0);
    check("rst_y",      64'(slot_y),      64'({SLOTS{10'(Y_START)}}));
    check("rst_score",  64'(score),       64'd0);
    check("rst_run",    64'(running),     64'd0);

    // Chart end with the last note hit, spawn ignored in DONE, exit to IDLE
    frame(0, 8'h2C, 8'h00, 0, 0);
    frame(0, 8'h00, 8'h00, 1, 0);
    idle(235);
    frame(0, LANE_KEY, 8'h00, 0, 1);
    check("end_done", 64'(running), 64'd0);
    frame(0, 8'h00, 8'h00, 1, 1);
    check("done_no_drop",  64'(spawn_drop),  64'd0);
    check("done_no_spawn", 64'(slot_active), 64'd0);
    check("done_score",    64'(score),       64'd2);
    frame(0, 8'h01, 8'h00, 0, 0);
    frame(0, 8'h2C, 8'h00, 0, 0);
    check("idle_to_run", 64'(running), 64'd1);

    // Random frames against the model
    start_run();
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 9);
      k1 = 8'h00;
      k2 = 8'h00;
      case (r)
        0, 1, 2: k1 = LANE_KEY;
        3:       k2 = LANE_KEY;
        4:       begin k1 = LANE_KEY; k2 = LANE_KEY; end
        5:       k1 = 8'h2C;
        6:       k2 = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
        7:       k1 = 8'($urandom_range(0, 255));
        default: ;
      endcase
      frame($urandom_range(0, 699) == 0, k1, k2,
            $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
